// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Writer side of the instruction-memory load path. Collects the byte stream
// from the UART receiver, assembles little-endian instruction words and
// presents each completed word to the instruction memory with a single-cycle
// write strobe. Loading stops after the HALT word has been written. Overflow
// (memory full at write time) and a stalled partial word (timeout) are
// reported as a sticky error.
//
// Ports
//   i_clk               rising-edge clock
//   i_reset_n           asynchronous active-low reset
//   i_start             one-cycle pulse arming a load (honoured in IDLE only)
//   i_rx_data[7:0]      received byte
//   i_rx_valid          one-cycle strobe qualifying i_rx_data
//   i_mem_full          instruction memory full flag (sampled in WRITE)
//   o_instruction       assembled word, valid while o_instruction_write is high
//   o_instruction_write single-cycle write strobe to the instruction memory
//   o_word_count        number of words written, HALT included
//   o_busy              high while a load is in progress
//   o_done              sticky, HALT has been written
//   o_error             sticky, overflow or timeout occurred
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MEM_SIZE_IN_WORDS  = 64,
    parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
    parameter int TIMEOUT_CYCLES     = 1_000_000
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_start,
    input  logic [7:0]                          i_rx_data,
    input  logic                                i_rx_valid,
    input  logic                                i_mem_full,
    output logic [WORD_SIZE_IN_BYTES*8-1:0]     o_instruction,
    output logic                                o_instruction_write,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_word_count,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_error
);

    localparam int WW = WORD_SIZE_IN_BYTES * 8;
    localparam int IW = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam int CW = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_WRITE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   byte_idx_reg;
    logic [WW-1:0]   assembly_reg;
    logic [WW-1:0]   instruction_reg;
    logic [CW-1:0]   word_count_reg;
    logic [TW-1:0]   timeout_reg;

    logic            busy;
    logic            byte_accept;
    logic            last_lane;
    logic            stall_cycle;
    logic            timeout_hit;
    logic            write_ok;
    logic [WW-1:0]   word_merged;

    assign busy        = (state_reg == ST_RECEIVE) || (state_reg == ST_WRITE) ||
                         (state_reg == ST_GAP);
    // Assembly keeps running through WRITE and GAP so back-to-back bytes are
    // never lost while the previous word is being written.
    assign byte_accept = i_rx_valid && busy;
    assign last_lane   = (byte_idx_reg == IW'(WORD_SIZE_IN_BYTES - 1));
    assign stall_cycle = (state_reg == ST_RECEIVE) && (byte_idx_reg != '0) && !i_rx_valid;
    assign timeout_hit = stall_cycle && (timeout_reg == TW'(TIMEOUT_CYCLES - 1));
    assign write_ok    = (state_reg == ST_WRITE) && !i_mem_full;

    // Current assembly with the incoming byte dropped into its lane, so the
    // completed word is available in the same cycle its last byte arrives.
    generate
        for (genvar gi = 0; gi < WORD_SIZE_IN_BYTES; gi++) begin : g_lane
            assign word_merged[gi*8 +: 8] = (byte_idx_reg == IW'(gi)) ? i_rx_data
                                                                       : assembly_reg[gi*8 +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (i_rx_valid && last_lane) begin
                    state_next = ST_WRITE;
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WRITE: begin
                // Overflow is checked before HALT detection.
                if (i_mem_full) begin
                    state_next = ST_ERROR;
                end else if (instruction_reg == HALT_INSTRUCTION) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_RECEIVE;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: byte assembly, word capture, word counter, timeout counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            byte_idx_reg    <= '0;
            assembly_reg    <= '0;
            instruction_reg <= '0;
            word_count_reg  <= '0;
            timeout_reg     <= '0;
        end else begin
            if (state_reg == ST_IDLE) begin
                if (i_start) begin
                    byte_idx_reg   <= '0;
                    assembly_reg   <= '0;
                    word_count_reg <= '0;
                    timeout_reg    <= '0;
                end
            end else begin
                if (byte_accept) begin
                    assembly_reg <= word_merged;
                    byte_idx_reg <= last_lane ? '0 : byte_idx_reg + IW'(1);
                    if ((state_reg == ST_RECEIVE) && last_lane) begin
                        instruction_reg <= word_merged;
                    end
                end

                if (write_ok) begin
                    word_count_reg <= word_count_reg + CW'(1);
                end

                // Counts idle cycles inside a partial word only; any accepted
                // byte or an empty word restarts it. Otherwise the value holds.
                if (byte_accept || (byte_idx_reg == '0)) begin
                    timeout_reg <= '0;
                end else if (stall_cycle) begin
                    timeout_reg <= timeout_reg + TW'(1);
                end
            end
        end
    end

    assign o_instruction       = instruction_reg;
    assign o_instruction_write = write_ok;
    assign o_word_count        = word_count_reg;
    assign o_busy              = busy;
    assign o_done              = (state_reg == ST_DONE);
    assign o_error             = (state_reg == ST_ERROR);

endmodule
